seq_control: RTL

SEQ_CONTROL -- requirements
Module: seq_control

---
 rtl/seq_control_if.sv | 35 +++
 rtl/seq_control.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/seq_control_if.sv
// seq_control_if: groups the sequencer's datapath-facing signals.
//   master : used by seq_control (samples start/instr/branch_taken/mem_ack,
//            drives strobes, status and counters)
//   slave  : used by the datapath / environment (the opposite view)
interface seq_control_if #(
   parameter int unsigned IW = 9
);
   logic          start;
   logic [IW-1:0] instr;
   logic          branch_taken;
   logic          mem_ack;
   logic          ir_load;
   logic          pc_inc;
   logic          pc_load;
   logic          mem_req;
   logic          mem_we;
   logic          rf_we;
   logic          mem_to_reg;
   logic          done;
   logic          err;
   logic [15:0]   instr_cnt;
   logic [15:0]   cycle_cnt;

   modport master (
      input  start, instr, branch_taken, mem_ack,
      output ir_load, pc_inc, pc_load, mem_req, mem_we, rf_we, mem_to_reg,
      output done, err, instr_cnt, cycle_cnt
   );

   modport slave (
      output start, instr, branch_taken, mem_ack,
      input  ir_load, pc_inc, pc_load, mem_req, mem_we, rf_we, mem_to_reg,
      input  done, err, instr_cnt, cycle_cnt
   );
endinterface

// File: rtl/seq_control.sv
// seq_control: multi-cycle instruction sequencer.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : seq_control_if.master
//                in : start, instr, branch_taken, mem_ack
//                out: ir_load, pc_inc, pc_load, mem_req, mem_we, rf_we,
//                     mem_to_reg, done, err, instr_cnt, cycle_cnt
// Flow: IDLE -> FETCH -> DECODE -> {EXEC | MEM [-> WB]} -> FETCH ..., HALT absorbs.
module seq_control #(
   parameter int unsigned   OPW       = 3,
   parameter int unsigned   IW        = 9,
   parameter int unsigned   TIMEOUT   = 8,
   parameter logic [IW-1:0] HALT_CODE = 9'h1FF
) (
   input logic          clk,
   input logic          reset,
   seq_control_if.master bus
);
   localparam int unsigned WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [OPW-1:0] OP_LOAD   = OPW'(0);
   localparam logic [OPW-1:0] OP_STORE  = OPW'(1);
   localparam logic [OPW-1:0] OP_BRANCH = OPW'(2);

   logic [2:0]     state_q, state_d;
   logic [OPW-1:0] opcode_q;
   logic [WW-1:0]  wait_q, wait_d;
   logic           err_q, err_d;
   logic [15:0]    instr_cnt_q, cycle_cnt_q;
   logic [OPW-1:0] op_in;

   logic ir_load, pc_inc, pc_load, mem_req, mem_we, rf_we, mem_to_reg;
   logic retire, active;

   // Opcode is decoded straight from instr in DECODE, latched for later states.
   assign op_in = bus.instr[IW-1 -: OPW];

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE:   if (bus.start) state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            if (bus.instr == HALT_CODE)                      state_d = S_HALT;
            else if (op_in == OP_LOAD || op_in == OP_STORE) state_d = S_MEM;
            else                                             state_d = S_EXEC;
         end
         S_EXEC:   state_d = S_FETCH;
         S_MEM: begin
            // An ack in the final wait cycle beats the timeout.
            if (bus.mem_ack) begin
               state_d = (opcode_q == OP_STORE) ? S_FETCH : S_WB;
            end else if (wait_q == WW'(TIMEOUT - 1)) begin
               state_d = S_HALT;
               err_d   = 1'b1;
            end
         end
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   // Wait counter restarts at 0 on every MEM entry.
   assign wait_d = (state_q == S_MEM && state_d == S_MEM) ? wait_q + 1'b1 : '0;

   always_comb begin
      ir_load    = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      rf_we      = 1'b0;
      mem_to_reg = 1'b0;
      case (state_q)
         S_FETCH: ir_load = 1'b1;
         S_EXEC: begin
            if (opcode_q == OP_BRANCH) begin
               pc_load = bus.branch_taken;
               pc_inc  = ~bus.branch_taken;
            end else begin
               rf_we  = 1'b1;
               pc_inc = 1'b1;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = (opcode_q == OP_STORE);
            pc_inc  = (opcode_q == OP_STORE) && bus.mem_ack;
         end
         S_WB: begin
            rf_we      = 1'b1;
            mem_to_reg = 1'b1;
            pc_inc     = 1'b1;
         end
         default: ;
      endcase
   end

   assign retire = pc_inc | pc_load;
   assign active = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                   (state_q == S_MEM) || (state_q == S_WB);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         opcode_q    <= '0;
         wait_q      <= '0;
         err_q       <= 1'b0;
         instr_cnt_q <= '0;
         cycle_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         if (state_q == S_DECODE) opcode_q <= op_in;
         if (retire && instr_cnt_q != 16'hFFFF) instr_cnt_q <= instr_cnt_q + 16'd1;
         if (active && cycle_cnt_q != 16'hFFFF) cycle_cnt_q <= cycle_cnt_q + 16'd1;
      end
   end

   assign bus.ir_load    = ir_load;
   assign bus.pc_inc     = pc_inc;
   assign bus.pc_load    = pc_load;
   assign bus.mem_req    = mem_req;
   assign bus.mem_we     = mem_we;
   assign bus.rf_we      = rf_we;
   assign bus.mem_to_reg = mem_to_reg;
   assign bus.done       = (state_q == S_HALT);
   assign bus.err        = err_q;
   assign bus.instr_cnt  = instr_cnt_q;
   assign bus.cycle_cnt  = cycle_cnt_q;
endmodule
